// File: rtl/data_sram_bridge_if.sv
// SRAM-like data bus between the MEM-stage bridge and the data memory system.
//   data_req      master->slave  request valid, held until data_addr_ok
//   data_wr       master->slave  1 = store
//   data_size     master->slave  0 = byte, 1 = half, 2 = word
//   data_addr     master->slave  byte address
//   data_wdata    master->slave  store data (lane-positioned)
//   data_addr_ok  slave->master  request accepted
//   data_rdata    slave->master  read data, valid with data_data_ok
//   data_data_ok  slave->master  transaction complete
interface data_sram_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_rdata, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_rdata, data_data_ok
  );
endinterface

// File: rtl/data_sram_bridge.sv
// Responder for the CPU MEM-stage data port. Each ena access becomes one
// transaction on the SRAM-like data bus; stall_req holds the pipeline until
// the transaction completes.
//   clk, reset          clock, synchronous active-high reset
//   ena, wea            access valid, byte-lane write enables (0 = load)
//   addra, dina         byte address, lane-positioned store data
//   douta               load data, held until the next load completes
//   stall_req           freeze IF..MEM
//   bus                 data bus master port
//
// state | meaning
// IDLE  | no access; ena latches a request (stall raised combinationally)
// REQ   | data_req high, waiting for data_addr_ok
// WAIT  | request accepted, waiting for data_data_ok
// DONE  | one unstalled cycle so the pipeline advances
module data_sram_bridge #(
  parameter bit ALIGN_LOADS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic [3:0]          wea,
  input  logic [31:0]         addra,
  input  logic [31:0]         dina,
  output logic [31:0]         douta,
  output logic                stall_req,
  data_sram_bridge_if.master  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [1:0]  size_dec;
  logic [1:0]  lane_dec;
  logic        capture;
  logic        load_done;

  // Access size and low address bits derived from the lane mask.
  always_comb begin
    size_dec = 2'd2;
    lane_dec = 2'd0;
    case (wea)
      4'b0000: lane_dec = ALIGN_LOADS ? 2'd0 : addra[1:0];
      4'b0001: begin size_dec = 2'd0; lane_dec = 2'd0; end
      4'b0010: begin size_dec = 2'd0; lane_dec = 2'd1; end
      4'b0100: begin size_dec = 2'd0; lane_dec = 2'd2; end
      4'b1000: begin size_dec = 2'd0; lane_dec = 2'd3; end
      4'b0011: begin size_dec = 2'd1; lane_dec = 2'd0; end
      4'b1100: begin size_dec = 2'd1; lane_dec = 2'd2; end
      default: begin size_dec = 2'd2; lane_dec = 2'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall_req    = 1'b0;
    capture      = 1'b0;
    load_done    = 1'b0;
    bus.data_req = 1'b0;
    case (state)
      IDLE: begin
        if (ena) begin
          stall_req = 1'b1;
          capture   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        stall_req    = 1'b1;
        bus.data_req = 1'b1;
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            load_done = ~req_wr;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall_req = 1'b1;
        if (bus.data_data_ok) begin
          load_done = ~req_wr;
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus fields come only from these registers, so they stay stable for the
  // whole REQ phase regardless of what the pipeline does meanwhile.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_wr    <= 1'b0;
      req_size  <= 2'd0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
      douta     <= 32'd0;
    end else begin
      if (capture) begin
        req_wr    <= |wea;
        req_size  <= size_dec;
        req_addr  <= {addra[31:2], lane_dec};
        req_wdata <= dina;
      end
      if (load_done) douta <= bus.data_rdata;
    end
  end

  assign bus.data_wr    = req_wr;
  assign bus.data_size  = req_size;
  assign bus.data_addr  = req_addr;
  assign bus.data_wdata = req_wdata;

endmodule
